// File: rtl/mcs51_if.sv
// Bus bundle between the mcs51_cpu core and its MCU wrapper.
// Covers code fetch, XDATA, external SFR access and the interrupt handshake.
interface mcs51_if;
  logic [15:0] code_addr;
  logic [7:0]  code_rdata;
  logic [15:0] xdata_addr;
  logic [7:0]  xdata_wdata;
  logic        xdata_we;
  logic        xdata_re;
  logic [7:0]  xdata_rdata;
  logic [7:0]  sfr_raddr;
  logic [7:0]  sfr_rdata;
  logic [7:0]  sfr_waddr;
  logic [7:0]  sfr_wdata;
  logic        sfr_we;
  logic        int_req;
  logic [15:0] int_vector;
  logic        int_prio;
  logic        int_ack;
  logic        reti_pulse;
  logic [7:0]  pcon_out;

  modport master (
    output code_addr, xdata_addr, xdata_wdata, xdata_we, xdata_re,
           sfr_raddr, sfr_waddr, sfr_wdata, sfr_we, int_ack, reti_pulse, pcon_out,
    input  code_rdata, xdata_rdata, sfr_rdata, int_req, int_vector, int_prio
  );

  modport slave (
    input  code_addr, xdata_addr, xdata_wdata, xdata_we, xdata_re,
           sfr_raddr, sfr_waddr, sfr_wdata, sfr_we, int_ack, reti_pulse, pcon_out,
    output code_rdata, xdata_rdata, sfr_rdata, int_req, int_vector, int_prio
  );
endinterface

// File: rtl/mcs51_cpu.sv
// Multi-cycle reduced 8051 core: FETCH -> OPERAND* -> EXEC, with a one-cycle INT entry state.
// Holds ACC, B, PSW, SP, DPTR, PCON and IRAM; every other SFR lives behind the bus.
module mcs51_cpu #(
  parameter int IRAM_SIZE = 128
) (
  input logic     clk,
  input logic     reset,
  mcs51_if.master bus
);
  // IRAM_SIZE is a power of two, so the modulo is a bit slice
  localparam int IW = $clog2(IRAM_SIZE);

  typedef enum logic [1:0] {S_FETCH, S_OPER, S_EXEC, S_INT} state_t;
  state_t state, state_nxt;

  logic [15:0] pc, dptr;
  logic [7:0]  acc, b, sp, pcon, ir, op1, op2;
  logic [7:1]  psw;
  logic        opi, isr_lo, isr_hi, int_hi_q;
  logic [7:0]  iram [IRAM_SIZE];

  logic [7:0]  psw_full, dir_rdata, rn_val, sp_top, sp_below, sp1, sp2, spm1, rn_dec;
  logic [IW-1:0] rn_idx;
  logic signed [7:0] rel;
  logic [15:0] rel_tgt;
  logic [10:0] alu_res;
  logic        accept, live, dwr_en, dwr_ext, xwe, xre, reti, ack;
  logic [7:0]  dwr_addr, dwr_data;

  function automatic logic [1:0] op_len(input logic [7:0] op);
    casez (op)
      8'h02, 8'h12, 8'h75, 8'h90: op_len = 2'd2;
      8'h80, 8'h74, 8'hE5, 8'hF5, 8'h24, 8'h34, 8'h94, 8'h54, 8'h44, 8'h64,
      8'h60, 8'h70, 8'hC0, 8'hD0, 8'b1101_1???: op_len = 2'd1;
      default: op_len = 2'd0;
    endcase
  endfunction

  // Returns {CY, AC, OV, result}; for subtraction CY/AC are borrows
  function automatic logic [10:0] alu_addsub(input logic [7:0] a, input logic [7:0] d,
                                              input logic cin, input logic sub);
    logic [8:0] r;
    logic [4:0] h;
    logic       ov;
    if (sub) begin
      r  = {1'b0, a} - {1'b0, d} - {8'd0, cin};
      h  = {1'b0, a[3:0]} - {1'b0, d[3:0]} - {4'd0, cin};
      ov = (a[7] != d[7]) && (r[7] != a[7]);
    end else begin
      r  = {1'b0, a} + {1'b0, d} + {8'd0, cin};
      h  = {1'b0, a[3:0]} + {1'b0, d[3:0]} + {4'd0, cin};
      ov = (a[7] == d[7]) && (r[7] != a[7]);
    end
    return {r[8], h[4], ov, r[7:0]};
  endfunction

  function automatic logic is_core_sfr(input logic [7:0] a);
    case (a)
      8'h81, 8'h82, 8'h83, 8'h87, 8'hD0, 8'hE0, 8'hF0: is_core_sfr = 1'b1;
      default: is_core_sfr = 1'b0;
    endcase
  endfunction

  assign psw_full = {psw, ^acc};
  assign sp1      = sp + 8'd1;
  assign sp2      = sp + 8'd2;
  assign spm1     = sp - 8'd1;
  assign sp_top   = iram[sp[IW-1:0]];
  assign sp_below = iram[spm1[IW-1:0]];
  assign rn_idx   = IW'({psw[4:3], ir[2:0]});
  assign rn_val   = iram[rn_idx];
  assign rn_dec   = rn_val - 8'd1;
  assign rel      = signed'(op1);
  assign rel_tgt  = pc + 16'(rel);
  assign alu_res  = alu_addsub(acc, op1, (ir != 8'h24) && psw[7], ir == 8'h94);
  assign live     = !reset;

  always_comb begin
    if (!op1[7]) dir_rdata = iram[op1[IW-1:0]];
    else begin
      case (op1)
        8'h81:   dir_rdata = sp;
        8'h82:   dir_rdata = dptr[7:0];
        8'h83:   dir_rdata = dptr[15:8];
        8'h87:   dir_rdata = pcon;
        8'hD0:   dir_rdata = psw_full;
        8'hE0:   dir_rdata = acc;
        8'hF0:   dir_rdata = b;
        default: dir_rdata = bus.sfr_rdata;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_nxt;
  end

  // RETI never hands over to INT directly: one instruction runs before the next entry
  always_comb begin
    state_nxt = state;
    dwr_en    = 1'b0;
    dwr_addr  = op1;
    dwr_data  = acc;
    xwe       = 1'b0;
    xre       = 1'b0;
    reti      = 1'b0;
    ack       = 1'b0;
    accept    = bus.int_req && (bus.int_prio ? !isr_hi : !(isr_hi || isr_lo));
    case (state)
      S_FETCH: state_nxt = (op_len(bus.code_rdata) == 2'd0) ? S_EXEC : S_OPER;
      S_OPER:  state_nxt = (op_len(ir) == 2'd2 && !opi) ? S_OPER : S_EXEC;
      S_EXEC: begin
        state_nxt = (accept && ir != 8'h32) ? S_INT : S_FETCH;
        case (ir)
          8'h75: begin dwr_en = 1'b1; dwr_data = op2; end
          8'hF5: dwr_en = 1'b1;
          8'hD0: begin dwr_en = 1'b1; dwr_data = sp_top; end
          8'hF0: xwe = 1'b1;
          8'hE0: xre = 1'b1;
          8'h32: reti = 1'b1;
          default: ;
        endcase
      end
      S_INT: begin
        ack       = 1'b1;
        state_nxt = S_FETCH;
      end
      default: state_nxt = S_FETCH;
    endcase
  end

  assign dwr_ext         = dwr_en && dwr_addr[7] && !is_core_sfr(dwr_addr);
  assign bus.sfr_we      = dwr_ext && live;
  assign bus.xdata_we    = xwe && live;
  assign bus.xdata_re    = xre && live;
  assign bus.reti_pulse  = reti && live;
  assign bus.int_ack     = ack && live;
  assign bus.sfr_waddr   = dwr_addr;
  assign bus.sfr_wdata   = dwr_data;
  assign bus.sfr_raddr   = op1;
  assign bus.code_addr   = pc;
  assign bus.xdata_addr  = dptr;
  assign bus.xdata_wdata = acc;
  assign bus.pcon_out    = pcon;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= 16'h0000; dptr <= 16'h0000; sp <= 8'h07;
      acc <= 8'h00; b <= 8'h00; psw <= 7'h00; pcon <= 8'h00;
      opi <= 1'b0; isr_lo <= 1'b0; isr_hi <= 1'b0; int_hi_q <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          ir  <= bus.code_rdata;
          pc  <= pc + 16'd1;
          opi <= 1'b0;
        end
        S_OPER: begin
          if (!opi) op1 <= bus.code_rdata;
          else      op2 <= bus.code_rdata;
          opi <= 1'b1;
          pc  <= pc + 16'd1;
        end
        S_EXEC: begin
          if (state_nxt == S_INT) int_hi_q <= bus.int_prio;
          casez (ir)
            8'h02: pc <= {op1, op2};
            8'h80: pc <= rel_tgt;
            8'h12: begin
              iram[sp1[IW-1:0]] <= pc[7:0];
              iram[sp2[IW-1:0]] <= pc[15:8];
              sp <= sp2;
              pc <= {op1, op2};
            end
            8'h22, 8'h32: begin
              pc <= {sp_top, sp_below};
              sp <= sp - 8'd2;
              if (ir[4]) begin
                if (isr_hi) isr_hi <= 1'b0;
                else        isr_lo <= 1'b0;
              end
            end
            8'h74: acc <= op1;
            8'hE5: acc <= dir_rdata;
            8'b1110_1???: acc <= rn_val;
            8'b1111_1???: iram[rn_idx] <= acc;
            8'h24, 8'h34, 8'h94: begin
              psw[7] <= alu_res[10];
              psw[6] <= alu_res[9];
              psw[2] <= alu_res[8];
              acc    <= alu_res[7:0];
            end
            8'h54: acc <= acc & op1;
            8'h44: acc <= acc | op1;
            8'h64: acc <= acc ^ op1;
            8'h04: acc <= acc + 8'd1;
            8'h14: acc <= acc - 8'd1;
            8'h60: if (acc == 8'h00) pc <= rel_tgt;
            8'h70: if (acc != 8'h00) pc <= rel_tgt;
            8'b1101_1???: begin
              iram[rn_idx] <= rn_dec;
              if (rn_dec != 8'h00) pc <= rel_tgt;
            end
            8'h90: dptr <= {op1, op2};
            8'hA3: dptr <= dptr + 16'd1;
            8'hE0: acc <= bus.xdata_rdata;
            8'hC0: begin
              iram[sp1[IW-1:0]] <= dir_rdata;
              sp <= sp1;
            end
            8'hD0: sp <= spm1;
            default: ;
          endcase
          // Direct writes come last so POP SP / MOV SP,#... keep the written value
          if (dwr_en) begin
            if (!dwr_addr[7]) iram[dwr_addr[IW-1:0]] <= dwr_data;
            else begin
              case (dwr_addr)
                8'h81: sp         <= dwr_data;
                8'h82: dptr[7:0]  <= dwr_data;
                8'h83: dptr[15:8] <= dwr_data;
                8'h87: pcon       <= dwr_data;
                8'hD0: psw        <= dwr_data[7:1];
                8'hE0: acc        <= dwr_data;
                8'hF0: b          <= dwr_data;
                default: ;
              endcase
            end
          end
        end
        S_INT: begin
          iram[sp1[IW-1:0]] <= pc[7:0];
          iram[sp2[IW-1:0]] <= pc[15:8];
          sp <= sp2;
          pc <= bus.int_vector;
          if (int_hi_q) isr_hi <= 1'b1;
          else          isr_lo <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mcs51_cpu.sv
// Self-checking bench for mcs51_cpu: directed programs plus randomized ALU programs
// whose results leave the core as external SFR writes and are checked against a reference model.
module tb_mcs51_cpu;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mcs51_if bus();
  mcs51_cpu #(.IRAM_SIZE(128)) dut (.clk(clk), .reset(reset), .bus(bus.master));

  logic [7:0]  code_mem [512];
  logic [7:0]  xr;
  logic [15:0] sfr_q[$];
  logic [15:0] exp_q[$];
  logic [23:0] xw_q[$];
  logic [15:0] xr_q[$];
  int n_assert = 0;
  int n_fail = 0;
  int cyc, wp, ack_cnt, reti_cnt, first_we;

  assign bus.code_rdata  = code_mem[bus.code_addr[8:0]];
  assign bus.xdata_rdata = xr;
  assign bus.sfr_rdata   = bus.sfr_raddr ^ 8'hCC;

  always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

  always @(negedge clk) begin
    if (bus.sfr_we) begin
      sfr_q.push_back({bus.sfr_waddr, bus.sfr_wdata});
      if (first_we < 0) first_we = cyc;
    end
    if (bus.xdata_we) xw_q.push_back({bus.xdata_addr, bus.xdata_wdata});
    if (bus.xdata_re) xr_q.push_back(bus.xdata_addr);
    if (bus.int_ack) ack_cnt++;
    if (bus.reti_pulse) reti_cnt++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_sfr(input string tag);
    chk({tag, "_count"}, sfr_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("%s_%0d", tag, i), (i < sfr_q.size()) ? {16'h0, sfr_q[i]} : 'x, {16'h0, exp_q[i]});
  endtask

  task automatic clear_code();
    for (int i = 0; i < 512; i++) code_mem[i] = 8'h00;
    wp = 0;
  endtask

  task automatic emit(input int n, input logic [127:0] bytes);
    for (int i = 0; i < n; i++) begin
      code_mem[wp[8:0]] = bytes[8*(n-1-i) +: 8];
      wp++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.int_req = 1'b0; bus.int_prio = 1'b0; bus.int_vector = 16'h0000;
    repeat (2) @(posedge clk);
    sfr_q.delete(); xw_q.delete(); xr_q.delete(); exp_q.delete();
    ack_cnt = 0; reti_cnt = 0; first_we = -1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_for(input int which, input int limit, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      seen = (which == 0) ? bus.int_ack : bus.reti_pulse;
    end
  endtask

  // Reference: 8051 arithmetic rules in plain integer form; returns {ACC, PSW}
  function automatic logic [15:0] ref_alu(input logic [7:0] op, input logic [7:0] a,
                                          input logic [7:0] k, input logic [7:0] psw0);
    int ua, uk, c, r, sr;
    logic cy, ac, ov;
    logic [7:0] res;
    ua = a; uk = k;
    cy = psw0[7]; ac = psw0[6]; ov = psw0[2];
    c = (op == 8'h24) ? 0 : int'(psw0[7]);
    case (op)
      8'h24, 8'h34: begin
        r  = ua + uk + c;
        sr = int'($signed(a)) + int'($signed(k)) + c;
        cy = (r > 255); ac = ((ua % 16) + (uk % 16) + c) > 15;
        ov = (sr > 127) || (sr < -128); res = 8'(r);
      end
      8'h94: begin
        r  = ua - uk - c;
        sr = int'($signed(a)) - int'($signed(k)) - c;
        cy = (r < 0); ac = (ua % 16) < ((uk % 16) + c);
        ov = (sr > 127) || (sr < -128); res = 8'(r);
      end
      8'h54: res = a & k;
      8'h44: res = a | k;
      8'h64: res = a ^ k;
      8'h04: res = 8'(ua + 1);
      8'h14: res = 8'(ua - 1);
      default: res = a;
    endcase
    return {res, cy, ac, psw0[5:3], ov, psw0[1], ^res};
  endfunction

  task automatic run_alu(input logic [7:0] op, input logic [7:0] a, input logic [7:0] k,
                         input logic [7:0] psw0, output logic [7:0] o_acc, output logic [7:0] o_psw);
    logic [15:0] e;
    clear_code();
    emit(3, {8'h75, 8'hD0, psw0});
    emit(2, {8'h74, a});
    if (op == 8'h04 || op == 8'h14) emit(1, op);
    else emit(2, {op, k});
    emit(8, 64'hF590_E5D0_F591_80FE);
    do_reset();
    repeat (35) @(negedge clk);
    e = ref_alu(op, a, k, psw0);
    o_acc = (sfr_q.size() > 0) ? sfr_q[0][7:0] : 'x;
    o_psw = (sfr_q.size() > 1) ? sfr_q[1][7:0] : 'x;
    exp_q.push_back({8'h90, e[15:8]});
    exp_q.push_back({8'h91, e[7:0]});
    chk_sfr($sformatf("alu_%h_%h_%h_%h", op, a, k, psw0));
  endtask

  initial begin
    logic [7:0] ra, rp, ops [8];
    bit seen;
    ops = '{8'h24, 8'h34, 8'h94, 8'h54, 8'h44, 8'h64, 8'h04, 8'h14};
    xr = 8'h00;
    bus.int_req = 1'b0; bus.int_prio = 1'b0; bus.int_vector = 16'h0000;

    // Reset state
    clear_code();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_code_addr", bus.code_addr, 16'h0000);
    chk("rst_strobes", {bus.sfr_we, bus.xdata_we, bus.xdata_re, bus.int_ack, bus.reti_pulse}, 0);
    chk("rst_pcon", bus.pcon_out, 8'h00);

    // Program A: external/internal SFR writes, PCON, external SFR read
    emit(12, 96'h745A_F590_F5E0_7591_3375_8780);
    emit(6, 48'hE5A0_F592_80FE);
    do_reset();
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("abort_sfr_we", bus.sfr_we, 1'b0);
    chk("abort_no_writes", sfr_q.size(), 0);
    do_reset();
    repeat (40) @(negedge clk);
    chk("first_we_cycle", first_we, 5);
    exp_q.push_back(16'h905A); exp_q.push_back(16'h9133); exp_q.push_back(16'h926C);
    chk_sfr("progA");
    chk("pcon_out", bus.pcon_out, 8'h80);

    // Directed ALU cases with hand-derived results
    run_alu(8'h24, 8'h7F, 8'h01, 8'h00, ra, rp);
    chk("add7f_acc", ra, 8'h80);
    chk("add7f_psw", rp, 8'h45);
    run_alu(8'h94, 8'h80, 8'h81, 8'h00, ra, rp);
    chk("subb_acc", ra, 8'hFF);
    chk("subb_cy", rp[7], 1'b1);

    // Randomized ALU programs
    for (int t = 0; t < 24; t++)
      run_alu(ops[$urandom_range(0, 7)], 8'($urandom), 8'($urandom), 8'($urandom), ra, rp);

    // DPTR and MOVX
    clear_code();
    xr = 8'h5E;
    emit(13, 104'h9012_3474_C3F0_E0A3_F0F5_9080_FE);
    do_reset();
    repeat (40) @(negedge clk);
    chk("xw_count", xw_q.size(), 2);
    chk("xw_first", (xw_q.size() > 0) ? xw_q[0] : 'x, 24'h1234C3);
    chk("xw_second", (xw_q.size() > 1) ? xw_q[1] : 'x, 24'h12355E);
    chk("xr_count", xr_q.size(), 1);
    chk("xr_addr", (xr_q.size() > 0) ? xr_q[0] : 'x, 16'h1234);
    exp_q.push_back(16'h905E);
    chk_sfr("movx");

    // LCALL / RET
    clear_code();
    emit(15, 120'h1201_00E5_08F5_90E5_09F5_91E5_81F5_92);
    emit(2, 16'h80FE);
    wp = 16'h0100;
    emit(5, 40'hE581_F593_22);
    do_reset();
    repeat (60) @(negedge clk);
    exp_q.push_back(16'h9309); exp_q.push_back(16'h9003);
    exp_q.push_back(16'h9100); exp_q.push_back(16'h9207);
    chk_sfr("call");

    // DJNZ loop and JZ
    clear_code();
    emit(14, 112'h7403_F8F5_9004_D8FB_E8F5_9160_0280);
    emit(6, 48'hFE75_92AA_80FE);
    do_reset();
    repeat (80) @(negedge clk);
    exp_q.push_back(16'h9003); exp_q.push_back(16'h9004); exp_q.push_back(16'h9005);
    exp_q.push_back(16'h9100); exp_q.push_back(16'h92AA);
    chk_sfr("djnz");

    // Interrupts: low entry, low re-request blocked, high preempts, RETI behaviour
    clear_code();
    emit(4, 32'h7411_80FE);
    wp = 16'h000B; emit(4, 32'hF590_80FE);
    wp = 16'h0013; emit(4, 32'h7591_2232);
    do_reset();
    repeat (4) @(negedge clk);
    bus.int_vector = 16'h000B; bus.int_prio = 1'b0; bus.int_req = 1'b1;
    wait_for(0, 20, seen);
    chk("int_low_ack", seen, 1'b1);
    @(negedge clk);
    chk("int_low_pc", bus.code_addr, 16'h000B);
    repeat (40) @(negedge clk);
    chk("int_low_blocked", ack_cnt, 1);
    bus.int_vector = 16'h0013; bus.int_prio = 1'b1;
    wait_for(0, 20, seen);
    chk("int_high_ack", seen, 1'b1);
    @(negedge clk);
    chk("int_high_pc", bus.code_addr, 16'h0013);
    wait_for(1, 20, seen);
    chk("reti_seen", seen, 1'b1);
    @(negedge clk);
    chk("no_ack_after_reti", bus.int_ack, 1'b0);
    chk("reti_return_pc", bus.code_addr, 16'h000D);
    wait_for(0, 10, seen);
    chk("int_high_reentry", seen, 1'b1);
    bus.int_req = 1'b0;
    wait_for(1, 20, seen);
    chk("reti_second", seen, 1'b1);
    bus.int_vector = 16'h000B; bus.int_prio = 1'b0; bus.int_req = 1'b1;
    repeat (40) @(negedge clk);
    chk("low_still_in_service", ack_cnt, 3);
    chk("reti_count", reti_cnt, 2);
    exp_q.push_back(16'h9011); exp_q.push_back(16'h9122); exp_q.push_back(16'h9122);
    chk_sfr("irq");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
